// File: rtl/fifo_tx_pkg.sv
// Shared types and frame constants for the event-FIFO serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: one-cycle tick every CLKDIV clocks, realigned by clear.
module bit_tick_gen
  import fifo_tx_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKDIV);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Event-FIFO read controller and UART-style serializer with locally generated parity.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int FIFO_WIDTH = 63,
  parameter int CLKDIV     = 4,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  read_n,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic [15:0]           words_sent
);

  localparam int BW = cnt_width(FIFO_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(FIFO_WIDTH - 1);

  tx_state_t             state;
  logic [FIFO_WIDTH-1:0] shift_q;
  logic [FIFO_WIDTH-1:0] shift_nx;
  logic                  parity_q;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  can_start;
  logic                  tick_clear;

  // Parity bit that makes the ones count over data+parity odd (or even).
  function automatic logic parity_of(input logic [FIFO_WIDTH-1:0] w);
    return (^w) ^ PARITY_ODD;
  endfunction

  assign can_start  = tx_enable && !fifo_empty;
  assign tick_clear = (state == REQ);
  assign shift_nx   = shift_q >> 1;

  bit_tick_gen #(
    .CLKDIV(CLKDIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

  // Word capture: fifo_data is valid by the edge that closes REQ.
  always_ff @(posedge clk) begin
    if (state == REQ) begin
      shift_q  <= fifo_data;
      parity_q <= parity_of(fifo_data);
    end else if (state == DATA && tick) begin
      shift_q  <= shift_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      read_n     <= 1'b1;
      tx_out     <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      words_sent <= '0;
      bit_cnt    <= '0;
    end else begin
      // The read strike is a single-cycle pulse; only the REQ entry lowers it.
      read_n <= 1'b1;
      case (state)
        IDLE: begin
          if (can_start) begin
            state   <= REQ;
            read_n  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        REQ: begin
          state   <= START;
          tx_out  <= START_BIT;
          bit_cnt <= '0;
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            tx_out <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state  <= PARITY;
              tx_out <= parity_q;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shift_nx[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            tx_out <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            words_sent <= words_sent + 1'b1;
            tx_out     <= IDLE_LEVEL;
            if (can_start) begin
              state  <= REQ;
              read_n <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_out  <= IDLE_LEVEL;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: frame decoder on the serial line, FIFO model, word scoreboard.
module tb_fifo_serial_tx;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FL = W + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          tx_enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          read_n, tx_out, tx_busy;
  logic [15:0]   words_sent;

  logic          en63;
  logic          empty63;
  logic [62:0]   data63;
  logic          read63_n, tx_out63, tx_busy63;
  logic [15:0]   words_sent63;

  fifo_serial_tx #(.FIFO_WIDTH(W), .CLKDIV(D), .PARITY_ODD(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .read_n(read_n), .tx_out(tx_out), .tx_busy(tx_busy),
    .words_sent(words_sent)
  );

  fifo_serial_tx #(.FIFO_WIDTH(63), .CLKDIV(4), .PARITY_ODD(1'b1)) u_dut63 (
    .clk(clk), .reset_n(reset_n), .tx_enable(en63), .fifo_empty(empty63),
    .fifo_data(data63), .read_n(read63_n), .tx_out(tx_out63), .tx_busy(tx_busy63),
    .words_sent(words_sent63)
  );

  // ---------------- FIFO models ----------------
  logic [W-1:0] mem [0:255];
  int           wr_cnt = 0, rd_cnt = 0;
  logic [62:0]  word63;
  int           wr63 = 0, rd63 = 0;
  bit           underflow = 1'b0;

  always_comb fifo_empty = (wr_cnt == rd_cnt);
  always_comb empty63    = (wr63 == rd63);

  initial begin
    fifo_data = '0;
    data63    = '0;
    forever begin
      @(negedge clk);
      if (read_n === 1'b0) begin
        if (rd_cnt < wr_cnt) begin
          fifo_data = mem[rd_cnt];
          rd_cnt++;
        end else underflow = 1'b1;
      end
      if (read63_n === 1'b0) begin
        if (rd63 < wr63) begin
          data63 = word63;
          rd63++;
        end else underflow = 1'b1;
      end
    end
  end

  // ---------------- line monitor / frame decoder ----------------
  int            cyc = 0;
  int            rd_pulses = 0, rd_fall_cyc = 0, busy_cycles = 0;
  bit            rd_wide = 1'b0;
  logic          rd_prev = 1'b1;
  logic [FL-1:0] fr_bits  [0:255];
  bit            fr_ok    [0:255];
  int            fr_start [0:255];
  int            fr_cnt = 0;
  bit            in_frame = 1'b0, fok, fabort;
  int            sidx, fstart;
  logic [FL-1:0] fbits;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (read_n === 1'b0) begin
      if (rd_prev === 1'b0) rd_wide = 1'b1;
      else begin
        rd_pulses++;
        rd_fall_cyc = cyc;
      end
    end
    rd_prev = read_n;
    if (tx_busy === 1'b1) busy_cycles++;
    if (!in_frame && reset_n === 1'b1 && tx_out === 1'b0) begin
      in_frame = 1'b1; sidx = 0; fbits = '0; fok = 1'b1; fabort = 1'b0; fstart = cyc;
    end
    if (in_frame) begin
      if (reset_n !== 1'b1) fabort = 1'b1;
      if (sidx % D == 0) fbits[sidx / D] = tx_out;
      else if (tx_out !== fbits[sidx / D]) fok = 1'b0;
      sidx++;
      if (sidx == FL * D) begin
        in_frame = 1'b0;
        if (!fabort) begin
          fr_bits[fr_cnt]  = fbits;
          fr_ok[fr_cnt]    = fok;
          fr_start[fr_cnt] = fstart;
          fr_cnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick2();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (fr_cnt < target && n < budget) begin
      tick2();
      n++;
    end
    check(name, (fr_cnt >= target), 1'b1);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rd_pulses < target && n < budget) begin
      tick2();
      n++;
    end
    check(name, (rd_pulses >= target), 1'b1);
  endtask

  // Reference frame: start, data LSB first, odd parity, stop (bit 0 sent first).
  function automatic logic [FL-1:0] frame8(input logic [W-1:0] w);
    logic p;
    p = ($countones(w) % 2 == 0);
    return {1'b1, p, w, 1'b0};
  endfunction

  typedef struct {
    logic [W-1:0]  data;
    logic [FL-1:0] frame;
  } vec_t;

  vec_t        tbl [7];
  logic [W-1:0] exp_q [$];

  initial begin
    int f0, p0, b0, n_rand, lowcnt;
    logic [15:0] ws0;
    logic [62:0] w63;
    logic [65:0] cap;
    bit          ok63;
    logic        busy_last;
    int          widx [3];

    tbl[0] = '{8'hA5, 11'b11101001010};
    tbl[1] = '{8'h00, 11'b11000000000};
    tbl[2] = '{8'hFF, 11'b11111111110};
    tbl[3] = '{8'h3C, 11'b11001111000};
    tbl[4] = '{8'h01, 11'b10000000010};
    tbl[5] = '{8'h80, 11'b10100000000};
    tbl[6] = '{8'h7F, 11'b10011111110};
    widx[0] = 0; widx[1] = 31; widx[2] = 62;

    reset_n = 1'b0; tx_enable = 1'b0; en63 = 1'b1; word63 = '0;
    repeat (3) @(negedge clk);
    tick2();
    check("reset tx_out", tx_out, 1'b1);
    check("reset read_n", read_n, 1'b1);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset words_sent", words_sent, 16'd0);
    check("reset63 tx_out", tx_out63, 1'b1);
    @(negedge clk); reset_n = 1'b1; tx_enable = 1'b1;

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      f0 = fr_cnt; p0 = rd_pulses; ws0 = words_sent; b0 = busy_cycles;
      @(negedge clk); push(tbl[i].data);
      wait_frames(f0 + 1, 200, "tbl frame timeout");
      repeat (3) tick2();
      check("tbl frame bits", fr_bits[f0], tbl[i].frame);
      check("tbl bit hold", fr_ok[f0], 1'b1);
      check("tbl read pulses", rd_pulses - p0, 1);
      check("tbl words_sent", words_sent, 16'(ws0 + 1));
      check("tbl busy cycles", busy_cycles - b0, 45);
      check("tbl start latency", fr_start[f0] - rd_fall_cyc, 1);
      check("tbl busy low", tx_busy, 1'b0);
    end

    // Back-to-back frames, then an empty FIFO with tx_enable high
    f0 = fr_cnt; p0 = rd_pulses; ws0 = words_sent;
    @(negedge clk); push(8'h00); push(8'hFF); push(8'h3C);
    wait_frames(f0 + 3, 600, "b2b timeout");
    repeat (3) tick2();
    check("b2b data0", fr_bits[f0][8:1], 8'h00);
    check("b2b data1", fr_bits[f0+1][8:1], 8'hFF);
    check("b2b data2", fr_bits[f0+2][8:1], 8'h3C);
    check("b2b parity0", fr_bits[f0][9], 1'b1);
    check("b2b parity1", fr_bits[f0+1][9], 1'b1);
    check("b2b parity2", fr_bits[f0+2][9], 1'b1);
    check("b2b gap01", fr_start[f0+1] - fr_start[f0], FL * D + 1);
    check("b2b gap12", fr_start[f0+2] - fr_start[f0+1], FL * D + 1);
    check("b2b read pulses", rd_pulses - p0, 3);
    check("b2b words_sent", words_sent, 16'(ws0 + 3));
    lowcnt = 0;
    repeat (100) begin
      tick2();
      if (read_n !== 1'b1 || tx_out !== 1'b1) lowcnt++;
    end
    check("empty idle lines", lowcnt, 0);
    check("empty read pulses", rd_pulses - p0, 3);

    // tx_enable dropped mid-DATA with two words queued
    f0 = fr_cnt; p0 = rd_pulses;
    @(negedge clk); tx_enable = 1'b0; push(8'h5A); push(8'hC3);
    repeat (5) tick2();
    check("disabled no read", rd_pulses - p0, 0);
    @(negedge clk); tx_enable = 1'b1;
    wait_pulses(p0 + 1, 10, "enable read timeout");
    repeat (20) @(posedge clk);
    @(negedge clk); tx_enable = 1'b0;
    wait_frames(f0 + 1, 100, "drop frame timeout");
    repeat (100) tick2();
    check("drop frame bits", fr_bits[f0], frame8(8'h5A));
    check("drop read pulses", rd_pulses - p0, 1);
    check("drop frame count", fr_cnt - f0, 1);
    check("drop busy low", tx_busy, 1'b0);
    @(negedge clk); tx_enable = 1'b1;
    wait_frames(f0 + 2, 100, "reenable timeout");
    repeat (3) tick2();
    check("reenable frame bits", fr_bits[f0+1], frame8(8'hC3));
    check("reenable read pulses", rd_pulses - p0, 2);

    // Reset during PARITY
    f0 = fr_cnt; p0 = rd_pulses;
    @(negedge clk); push(8'h97);
    wait_pulses(p0 + 1, 10, "rst read timeout");
    while (cyc < rd_fall_cyc + 38) tick2();
    check("pre-reset parity level", tx_out, 1'b0);
    check("pre-reset busy", tx_busy, 1'b1);
    @(negedge clk); reset_n = 1'b0;
    tick2();
    check("rst tx_out", tx_out, 1'b1);
    check("rst read_n", read_n, 1'b1);
    check("rst words_sent", words_sent, 16'd0);
    check("rst tx_busy", tx_busy, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    repeat (100) tick2();
    check("rst no frame", fr_cnt - f0, 0);
    check("rst not resent", rd_pulses - p0, 1);
    check("rst words stay", words_sent, 16'd0);

    // Randomized traffic against the word scoreboard
    f0 = fr_cnt; p0 = rd_pulses; ws0 = words_sent; n_rand = 0;
    for (int r = 0; r < 10; r++) begin
      int gap, burst;
      logic [W-1:0] w;
      gap = $urandom_range(0, 80);
      burst = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < burst; k++) begin
        w = W'($urandom);
        push(w);
        exp_q.push_back(w);
        n_rand++;
      end
    end
    wait_frames(f0 + n_rand, n_rand * 50 + 200, "rand timeout");
    repeat (3) tick2();
    for (int i = 0; i < n_rand; i++) begin
      check("rand frame bits", fr_bits[f0+i], frame8(exp_q[i]));
      check("rand bit hold", fr_ok[f0+i], 1'b1);
    end
    check("rand words_sent", words_sent, 16'(ws0 + n_rand));
    check("rand read pulses", rd_pulses - p0, n_rand);

    // Default width with walking-ones words
    for (int t = 0; t < 3; t++) begin
      int n;
      logic [15:0] ws63;
      w63 = 63'(1) << widx[t];
      ws63 = words_sent63;
      @(negedge clk); word63 = w63; wr63++;
      n = 0;
      while (tx_out63 !== 1'b0 && n < 20) begin
        tick2();
        n++;
      end
      check("w63 start seen", tx_out63, 1'b0);
      cap = '0; ok63 = 1'b1; busy_last = 1'b0;
      for (int s = 0; s < 264; s++) begin
        if (s > 0) tick2();
        if (s % 4 == 0) cap[s/4] = tx_out63;
        else if (tx_out63 !== cap[s/4]) ok63 = 1'b0;
        if (s == 263) busy_last = tx_busy63;
      end
      tick2();
      check("w63 frame bits", cap, {1'b1, 1'b0, w63, 1'b0});
      check("w63 bit hold", ok63, 1'b1);
      check("w63 busy at last bit", busy_last, 1'b1);
      check("w63 busy after frame", tx_busy63, 1'b0);
      check("w63 words_sent", words_sent63, 16'(ws63 + 1));
    end

    check("read pulse width", rd_wide, 1'b0);
    check("no read while empty", underflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
